// File: rtl/sync_fifo_pkg.sv
// Shared types for the FWFT adapter.
// Contents:
//   occ_state_e - occupancy state of the 2-entry skid buffer (EMPTY/ONE/TWO);
//                 the encoding equals the number of buffered words.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/sync_fifo_fwft_adapter_if.sv
// Downstream first-word-fall-through valid/ready stream.
// Signals:
//   m_valid - stream valid (driven by the adapter)
//   m_ready - stream ready (driven by the consumer)
//   m_data  - stream data, WIDTH bits (driven by the adapter)
// Modports: master = adapter side, slave = consumer side.
interface sync_fifo_fwft_adapter_if #(
  parameter int WIDTH = 32
) ();

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fwft_skid_buf.sv
// Two-entry register storage with head/tail pointers.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clr        - synchronous pointer clear (discard contents)
//   wr_en      - write wr_data at the tail
//   wr_data    - word to write
//   rd_en      - retire the head entry
//   rd_data    - current head entry (registered storage, no read latency)
// The caller guarantees no write when full and no read when empty.
module fwft_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;

  // Head/tail pointers; clr wins over any simultaneous read or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else if (clr) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_r <= ~wr_ptr_r;
      if (rd_en) rd_ptr_r <= ~rd_ptr_r;
    end
  end

  // Storage registers; cleared on reset so the head never reads as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else if (wr_en && !clr) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/sync_fifo_fwft_adapter.sv
// Converts a FIFO's pop / one-cycle-latency read port into a
// first-word-fall-through valid/ready stream with a 2-entry skid buffer.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   flush      - synchronous discard of buffered and in-flight data
//   is_empty   - FIFO empty flag
//   data_out   - FIFO read data, valid one cycle after pop
//   pop        - FIFO read strobe (combinational)
//   occupancy  - buffered words 0..2, excluding the word in flight
//   m_if       - downstream stream (master modport)
import sync_fifo_pkg::*;

module sync_fifo_fwft_adapter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             is_empty,
  input  logic [WIDTH-1:0]                 data_out,
  output logic                             pop,
  output logic [1:0]                       occupancy,
  sync_fifo_fwft_adapter_if.master         m_if
);

  localparam logic [2:0] CAPACITY = 3'(DEPTH);

  occ_state_e       state_r;
  occ_state_e       state_nxt_s;
  logic             inflight_r;
  logic             m_valid_s;
  logic             fire_s;
  logic             capture_s;
  logic             pop_s;
  logic [2:0]       pending_s;
  logic [WIDTH-1:0] head_data_s;

  assign m_valid_s = (state_r != EMPTY);
  assign fire_s    = m_valid_s && m_if.m_ready;
  assign capture_s = inflight_r && !flush;

  // Words that will be held after this edge if nothing new is popped;
  // popping only while this is below capacity means a returning word
  // always finds a free slot.
  always_comb begin
    pending_s = {1'b0, state_r} + {2'b00, inflight_r} - {2'b00, fire_s};
    pop_s     = rst_n && !is_empty && !flush && (pending_s < CAPACITY);
  end

  // Occupancy next state: flush first, then capture (+1) and fire (-1).
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else if (capture_s && !fire_s) begin
      case (state_r)
        EMPTY:   state_nxt_s = ONE;
        ONE:     state_nxt_s = TWO;
        default: state_nxt_s = TWO;
      endcase
    end else if (fire_s && !capture_s) begin
      case (state_r)
        TWO:     state_nxt_s = ONE;
        ONE:     state_nxt_s = EMPTY;
        default: state_nxt_s = EMPTY;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register and in-flight flag (pop_s is already low during flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= pop_s;
    end
  end

  fwft_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (capture_s),
    .wr_data (data_out),
    .rd_en   (fire_s),
    .rd_data (head_data_s)
  );

  assign pop         = pop_s;
  assign occupancy   = state_r;
  assign m_if.m_valid = m_valid_s;
  assign m_if.m_data  = head_data_s;

endmodule

// File: tb/tb_sync_fifo_fwft_adapter.sv
// Self-checking bench for sync_fifo_fwft_adapter: a small FIFO model feeds
// the adapter, a queue-based model of the adapter is checked every cycle,
// and directed scenarios pin delivered words and cycles with literals.
module tb_sync_fifo_fwft_adapter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         is_empty;
  logic [W-1:0] data_out = '0;
  logic         pop;
  logic [1:0]   occupancy;

  sync_fifo_fwft_adapter_if #(.WIDTH(W)) s_if ();

  sync_fifo_fwft_adapter #(.WIDTH(W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .is_empty  (is_empty),
    .data_out  (data_out),
    .pop       (pop),
    .occupancy (occupancy),
    .m_if      (s_if)
  );

  always #5 clk = ~clk;

  // ---------------- upstream FIFO model ----------------
  logic [W-1:0] fifo_mem [0:63];
  int           wr_idx = 0;
  int           rd_idx = 0;

  assign is_empty = (rd_idx == wr_idx);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx   <= wr_idx;
      data_out <= '0;
    end else if (flush) begin
      rd_idx <= wr_idx;
    end else if (pop) begin
      data_out <= fifo_mem[rd_idx];
      rd_idx   <= rd_idx + 1;
    end
  end

  task automatic push(input logic [W-1:0] v);
    fifo_mem[wr_idx] = v;
    wr_idx = wr_idx + 1;
  endtask

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Adapter model: words held downstream-visible, plus one word in flight.
  logic [W-1:0] mbuf [$];
  bit           minfl = 1'b0;
  int           cyc = 0;
  int           pop_log [$];
  int           fire_cyc_log [$];
  logic [W-1:0] fire_data_log [$];

  task automatic clear_logs();
    pop_log.delete();
    fire_cyc_log.delete();
    fire_data_log.delete();
  endtask

  // Inputs change only just after posedge, so at negedge they are the
  // values the next edge will see.
  initial begin
    bit fire;
    bit exp_pop;
    int sz;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_valid", 64'(s_if.m_valid), 64'd0);
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_data", 64'(s_if.m_data), 64'd0);
        mbuf.delete();
        minfl = 1'b0;
      end else begin
        sz      = mbuf.size();
        fire    = (sz != 0) && s_if.m_ready;
        exp_pop = !is_empty && !flush && ((sz + int'(minfl) - int'(fire)) < 2);
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("m_valid", 64'(s_if.m_valid), 64'(sz != 0));
        if (sz != 0) chk("m_data", 64'(s_if.m_data), 64'(mbuf[0]));
        chk("pop", 64'(pop), 64'(exp_pop));
        if (pop) pop_log.push_back(cyc);
        if (flush) begin
          mbuf.delete();
          minfl = 1'b0;
        end else begin
          if (fire) begin
            fire_data_log.push_back(mbuf[0]);
            fire_cyc_log.push_back(cyc);
            void'(mbuf.pop_front());
          end
          if (minfl) mbuf.push_back(data_out);
          minfl = pop;
        end
      end
      cyc = cyc + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] dat_at(input int i);
    if (i < fire_data_log.size()) return 64'(fire_data_log[i]);
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic int fcyc_at(input int i);
    if (i < fire_cyc_log.size()) return fire_cyc_log[i];
    return -1000;
  endfunction

  function automatic int pcyc_at(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return -1000;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    logic [W-1:0] exp_a [5];
    s_if.m_ready = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Three preloaded words, consumer always ready: no bubbles.
    clear_logs();
    s_if.m_ready = 1'b1;
    push(32'h11); push(32'h22); push(32'h33);
    base = cyc;
    step(8);
    chk("t1_npop", 64'(pop_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("t1_pop_cyc", 64'(pcyc_at(i) - base), 64'(i));
    chk("t1_nfire", 64'(fire_data_log.size()), 64'd3);
    chk("t1_d0", dat_at(0), 64'h11);
    chk("t1_d1", dat_at(1), 64'h22);
    chk("t1_d2", dat_at(2), 64'h33);
    for (int i = 0; i < 3; i++) chk("t1_fire_cyc", 64'(fcyc_at(i) - base), 64'(i + 2));

    // Five words, consumer stalled: exactly two pops, head held.
    clear_logs();
    s_if.m_ready = 1'b0;
    exp_a[0] = 32'hA1; exp_a[1] = 32'hA2; exp_a[2] = 32'hA3; exp_a[3] = 32'hA4; exp_a[4] = 32'hA5;
    for (int i = 0; i < 5; i++) push(exp_a[i]);
    step(8);
    chk("t2_npop", 64'(pop_log.size()), 64'd2);
    chk("t2_occ", 64'(occupancy), 64'd2);
    chk("t2_pop", 64'(pop), 64'd0);
    chk("t2_valid", 64'(s_if.m_valid), 64'd1);
    chk("t2_head", 64'(s_if.m_data), 64'hA1);
    s_if.m_ready = 1'b1;
    step(10);
    chk("t2_nfire", 64'(fire_data_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("t2_order", dat_at(i), 64'(exp_a[i]));

    // Toggling ready, four words: all delivered in order.
    clear_logs();
    push(32'hB1); push(32'hB2); push(32'hB3); push(32'hB4);
    for (int i = 0; i < 16; i++) begin
      s_if.m_ready = (i % 2 == 0);
      step(1);
    end
    s_if.m_ready = 1'b1;
    step(4);
    chk("t3_nfire", 64'(fire_data_log.size()), 64'd4);
    chk("t3_d0", dat_at(0), 64'hB1);
    chk("t3_d1", dat_at(1), 64'hB2);
    chk("t3_d2", dat_at(2), 64'hB3);
    chk("t3_d3", dat_at(3), 64'hB4);

    // Flush the cycle after a pop while one word is buffered.
    clear_logs();
    s_if.m_ready = 1'b0;
    push(32'hC1); push(32'hC2);
    step(2);
    chk("t4_occ_pre", 64'(occupancy), 64'd1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t4_valid_post", 64'(s_if.m_valid), 64'd0);
    chk("t4_occ_post", 64'(occupancy), 64'd0);
    step(2);
    chk("t4_still_empty", 64'(s_if.m_valid), 64'd0);
    push(32'hC3);
    s_if.m_ready = 1'b1;
    step(6);
    chk("t4_nfire", 64'(fire_data_log.size()), 64'd1);
    chk("t4_first", dat_at(0), 64'hC3);

    // FIFO empty throughout, random ready.
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      s_if.m_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    chk("t5_npop", 64'(pop_log.size()), 64'd0);
    chk("t5_nfire", 64'(fire_data_log.size()), 64'd0);

    // Asynchronous reset with two words buffered, then clean restart.
    clear_logs();
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'hD1 + 32'(i));
    step(4);
    chk("t6_occ_pre", 64'(occupancy), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(s_if.m_valid), 64'd0);
    chk("t6_async_occ", 64'(occupancy), 64'd0);
    chk("t6_async_pop", 64'(pop), 64'd0);
    chk("t6_async_data", 64'(s_if.m_data), 64'd0);
    step(2);
    rst_n = 1'b1;
    clear_logs();
    s_if.m_ready = 1'b1;
    push(32'hE1); push(32'hE2); push(32'hE3);
    base = cyc;
    step(8);
    chk("t6_nfire", 64'(fire_data_log.size()), 64'd3);
    chk("t6_d0", dat_at(0), 64'hE1);
    chk("t6_d1", dat_at(1), 64'hE2);
    chk("t6_d2", dat_at(2), 64'hE3);
    chk("t6_first_cyc", 64'(fcyc_at(0) - base), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
